// File: rtl/fir_tail_flusher.sv
// Upstream AXI-stream stage for the polyphase interpolator: passes samples through and
// appends FLUSH_LENGTH zero samples after each frame, moving tlast onto the final zero.
module fir_tail_flusher #(
  parameter int DATA_WIDTH   = 16,
  parameter int FLUSH_LENGTH = 4,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  data_in_tdata,
  input  logic                   data_in_tvalid,
  input  logic                   data_in_tlast,
  output logic                   data_in_tready,
  output logic [DATA_WIDTH-1:0]  data_out_tdata,
  output logic                   data_out_tvalid,
  output logic                   data_out_tlast,
  input  logic                   data_out_tready,
  output logic                   flushing,
  output logic [COUNT_WIDTH-1:0] frame_count
);

  localparam int CNT_W = (FLUSH_LENGTH > 0) ? $clog2(FLUSH_LENGTH + 1) : 1;
  localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(FLUSH_LENGTH);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic {
    S_PASS  = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;
  logic                    tlast_q, tlast_d;
  logic                    tvalid_q, tvalid_d;
  logic [COUNT_WIDTH-1:0]  frame_q, frame_d;
  logic                    slot_free;
  logic                    in_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tdata_d   = tdata_q;
    tlast_d   = tlast_q;
    tvalid_d  = tvalid_q;
    frame_d   = frame_q;
    in_ready  = 1'b0;
    slot_free = !tvalid_q || data_out_tready;

    // The current beat leaves this cycle; a new load below overrides the clear.
    if (tvalid_q && data_out_tready) begin
      tvalid_d = 1'b0;
      if (tlast_q) begin
        frame_d = frame_q + COUNT_WIDTH'(1);
      end
    end

    case (state_q)
      S_PASS: begin
        in_ready = slot_free;
        if (data_in_tvalid && slot_free) begin
          tdata_d  = data_in_tdata;
          tvalid_d = 1'b1;
          tlast_d  = 1'b0;
          if (data_in_tlast) begin
            if (FLUSH_LENGTH > 0) begin
              state_d = S_FLUSH;
              cnt_d   = FLUSH_INIT;
            end else begin
              tlast_d = 1'b1;
            end
          end
        end
      end
      S_FLUSH: begin
        if (slot_free) begin
          tdata_d  = '0;
          tvalid_d = 1'b1;
          tlast_d  = (cnt_q == CNT_ONE);
          cnt_d    = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = S_PASS;
          end
        end
      end
      default: state_d = S_PASS;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_PASS;
      cnt_q    <= '0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
      frame_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      tvalid_q <= tvalid_d;
      frame_q  <= frame_d;
    end
  end

  assign data_in_tready  = in_ready;
  assign data_out_tdata  = tdata_q;
  assign data_out_tvalid = tvalid_q;
  assign data_out_tlast  = tlast_q;
  assign flushing        = (state_q == S_FLUSH);
  assign frame_count     = frame_q;

endmodule
